regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU / load) write-port arbiter for a register file, round-robin or mem-priority with starvation guard.
// Optional forwarding outputs are enabled by defining REGFILE_ARB_FWD_EN.
module regfile_write_arbiter #(
  parameter int unsigned PRIO_MEM     = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        write_enable,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  input  logic [4:0]  read_index1,
  input  logic [4:0]  read_index2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        last_mem_q, last_mem_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grant_alu_s, grant_mem_s;
  logic [4:0]  sel_reg_s;
  logic [31:0] sel_data_s;

  // Winner selection; reset and hold suppress every grant.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_mem_s = 1'b0;
    if (!reset && !hold) begin
      if (alu_valid && mem_valid) begin
        if (PRIO_MEM != 0) begin
          if (starve_q == STARVE_MAX) begin
            grant_alu_s = 1'b1;
          end else begin
            grant_mem_s = 1'b1;
          end
        end else if (last_mem_q) begin
          grant_alu_s = 1'b1;
        end else begin
          grant_mem_s = 1'b1;
        end
      end else begin
        grant_alu_s = alu_valid;
        grant_mem_s = mem_valid;
      end
    end else begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
    end
  end

  assign alu_ready  = grant_alu_s;
  assign mem_ready  = grant_mem_s;
  assign sel_reg_s  = grant_mem_s ? mem_reg  : alu_reg;
  assign sel_data_s = grant_mem_s ? mem_data : alu_data;

  // Next-state: writes to r0 are accepted but never reach the write port.
  always_comb begin
    state_d    = IDLE;
    last_mem_d = last_mem_q;
    starve_d   = starve_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (grant_alu_s || grant_mem_s) begin
      last_mem_d = grant_mem_s;
      if (sel_reg_s != 5'd0) begin
        state_d = WRITE;
        wreg_d  = sel_reg_s;
        wdata_d = sel_data_s;
      end else begin
        state_d = IDLE;
      end
    end else begin
      state_d = IDLE;
    end
    if (PRIO_MEM == 0 || hold) begin
      starve_d = starve_q;
    end else if (!alu_valid || grant_alu_s) begin
      starve_d = 4'd0;
    end else begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State and write-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_mem_q <= 1'b0;
      starve_q   <= 4'd0;
      wreg_q     <= 5'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_mem_q <= last_mem_d;
      starve_q   <= starve_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign write_enable = (state_q == WRITE);
  assign write_reg    = wreg_q;
  assign write_data   = wdata_q;

`ifdef REGFILE_ARB_FWD_EN
  assign fwd_hit1 = write_enable && (write_reg == read_index1) && (read_index1 != 5'd0);
  assign fwd_hit2 = write_enable && (write_reg == read_index2) && (read_index2 != 5'd0);
  assign fwd_data = write_data;
`else
  assign fwd_hit1 = 1'b0;
  assign fwd_hit2 = 1'b0;
  assign fwd_data = 32'd0;
`endif

endmodule
